lsu: RTL and testbench

Load/store unit in the MEM stage of the pipelined core, directly upstream of the data memory. Converts a decoded load/store into the memory's write-enable encoding and address, and sign/zero-extends returned load data. Splits misaligned accesses into multi-cycle sequences and stalls the pipeline until they finish. Aligned accesses complete combinationally in the acceptance cycle.

---
 rtl/lsu_pkg.sv | 48 ++++
 rtl/lsu_load_align.sv | 25 ++
 rtl/lsu.sv | 141 ++++++++++++++
 tb/tb_lsu.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, data-memory write-enable
// codes, FSM states and small access-decode helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] WE_WORD = 4'b1000;
    localparam logic [3:0] WE_HALF = 4'b0010;
    localparam logic [3:0] WE_BYTE = 4'b0001;
    localparam logic [3:0] WE_NONE = 4'b0000;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LD_HI   = 2'd1;
    localparam logic [1:0] S_ST_BYTE = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = S_IDLE,
        LD_HI   = S_LD_HI,
        ST_BYTE = S_ST_BYTE
    } lsu_state_t;

    // Access size in bytes; only meaningful for legal funct3 values.
    function automatic logic [2:0] access_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return 3'd1;
            F3_H, F3_HU: return 3'd2;
            default:     return 3'd4;
        endcase
    endfunction

    function automatic logic f3_legal(input logic store, input logic [2:0] f3);
        if (store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic [3:0] we_for_size(input logic [2:0] size);
        case (size)
            3'd1:    return WE_BYTE;
            3'd2:    return WE_HALF;
            default: return WE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts a byte/half/word from a 64-bit little-endian window at a byte offset
// and sign- or zero-extends it according to the load funct3.
module load_align
    import lsu_pkg::*;
(
    input  logic [63:0] window,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);
    logic [63:0] shifted;

    always_comb begin
        shifted = window >> {offset, 3'b000};
        case (funct3)
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    result = shifted[31:0];
            F3_BU:   result = {24'b0, shifted[7:0]};
            F3_HU:   result = {16'b0, shifted[15:0]};
            default: result = 32'b0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit: drives data-memory address/enables, extends load data,
// and sequences misaligned accesses while stalling the pipeline.
module lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        fault,
    output logic [3:0]  dmem_we,
    output logic [31:0] dmem_a,
    output logic [31:0] dmem_wd,
    input  logic [31:0] dmem_rd,
    output lsu_state_t  dbg_state
);
    // Handshake: req_* is sampled only in IDLE; while stall is high the pipeline holds
    // the same request, which is ignored until the cycle where stall drops.
    lsu_state_t  state, next_state;
    logic [1:0]  cnt, last_cnt;
    logic [31:0] lo_buf, lat_addr, lat_wdata;
    logic [2:0]  lat_f3;

    logic        go, legal, misal_st, crossing;
    logic [2:0]  req_size, end_off;
    logic [63:0] window;
    logic [1:0]  offset;
    logic [2:0]  align_f3;
    logic [31:0] aligned;
    logic [7:0]  st_byte;

    assign go       = req_valid && !reset;
    assign legal    = f3_legal(req_store, req_funct3);
    assign req_size = access_size(req_funct3);
    assign end_off  = {1'b0, req_addr[1:0]} + req_size;
    assign crossing = end_off > 3'd4;
    assign misal_st = ((req_size == 3'd2) && req_addr[0]) ||
                      ((req_size == 3'd4) && (req_addr[1:0] != 2'b00));
    assign dbg_state = state;

    always_comb begin
        case (cnt)
            2'd0:    st_byte = lat_wdata[7:0];
            2'd1:    st_byte = lat_wdata[15:8];
            2'd2:    st_byte = lat_wdata[23:16];
            default: st_byte = lat_wdata[31:24];
        endcase
    end

    load_align u_align (
        .window (window),
        .offset (offset),
        .funct3 (align_f3),
        .result (aligned)
    );

    always_comb begin
        stall      = 1'b0;
        resp_valid = 1'b0;
        fault      = 1'b0;
        dmem_we    = WE_NONE;
        dmem_a     = req_addr;
        dmem_wd    = req_wdata;
        window     = {32'b0, dmem_rd};
        offset     = req_addr[1:0];
        align_f3   = req_funct3;
        next_state = state;
        case (state)
            IDLE: begin
                if (go) begin
                    if (!legal) begin
                        fault = 1'b1;
                    end else if (req_store) begin
                        if (misal_st) begin
                            dmem_we    = WE_BYTE;
                            dmem_wd    = {24'b0, req_wdata[7:0]};
                            stall      = 1'b1;
                            next_state = ST_BYTE;
                        end else begin
                            dmem_we = we_for_size(req_size);
                        end
                    end else if (crossing) begin
                        dmem_a     = {req_addr[31:2], 2'b00};
                        stall      = 1'b1;
                        next_state = LD_HI;
                    end else begin
                        resp_valid = 1'b1;
                    end
                end
            end
            LD_HI: begin
                dmem_a     = {lat_addr[31:2], 2'b00} + 32'd4;
                window     = {dmem_rd, lo_buf};
                offset     = lat_addr[1:0];
                align_f3   = lat_f3;
                resp_valid = 1'b1;
                next_state = IDLE;
            end
            ST_BYTE: begin
                dmem_we    = WE_BYTE;
                dmem_a     = lat_addr + {30'b0, cnt};
                dmem_wd    = {24'b0, st_byte};
                stall      = (cnt != last_cnt);
                next_state = (cnt == last_cnt) ? IDLE : ST_BYTE;
            end
            default: next_state = IDLE;
        endcase
        resp_rdata = resp_valid ? aligned : 32'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            last_cnt  <= 2'd0;
            lo_buf    <= 32'b0;
            lat_addr  <= 32'b0;
            lat_wdata <= 32'b0;
            lat_f3    <= 3'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state != IDLE) begin
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_f3    <= req_funct3;
                last_cnt  <= 2'(req_size - 3'd1);
            end
            if (next_state == LD_HI) lo_buf <= dmem_rd;
            // cnt indexes the byte being written in ST_BYTE; byte 0 goes out from IDLE.
            if (state == IDLE && next_state == ST_BYTE) cnt <= 2'd1;
            else if (state == ST_BYTE) cnt <= (cnt == last_cnt) ? 2'd0 : cnt + 2'd1;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: byte-array memory environment, byte-level reference model feeding
// expected-load and expected-write queues, and a negedge monitor that pops and compares.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        stall, resp_valid, fault;
    logic [31:0] resp_rdata, dmem_a, dmem_wd, dmem_rd;
    logic [3:0]  dmem_we;
    lsu_state_t  dbg_state;

    int checks = 0;
    int failures = 0;

    logic [7:0]  mem     [256] = '{default: 8'h00};
    logic [7:0]  ref_mem [256] = '{default: 8'h00};
    logic [31:0] exp_q   [$];
    logic [67:0] exp_w_q [$];

    lsu dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .fault      (fault),
        .dmem_we    (dmem_we),
        .dmem_a     (dmem_a),
        .dmem_wd    (dmem_wd),
        .dmem_rd    (dmem_rd),
        .dbg_state  (dbg_state)
    );

    // clock / memory environment
    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < 4; k++) dmem_rd[8*k +: 8] = mem[{dmem_a[7:2], 2'b00} + 8'(k)];
    end

    always @(posedge clk) begin
        if (dmem_we == WE_WORD) begin
            for (int k = 0; k < 4; k++) mem[dmem_a[7:0] + 8'(k)] <= dmem_wd[8*k +: 8];
        end else if (dmem_we == WE_HALF) begin
            for (int k = 0; k < 2; k++) mem[dmem_a[7:0] + 8'(k)] <= dmem_wd[8*k +: 8];
        end else if (dmem_we == WE_BYTE) begin
            mem[dmem_a[7:0]] <= dmem_wd[7:0];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_w(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL resp_unexpected: actual=%h expected=none", resp_rdata);
                end else begin
                    check("resp_rdata", resp_rdata, exp_q.pop_front());
                end
            end
            if (dmem_we != WE_NONE) begin
                if (exp_w_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL write_unexpected: actual=%h expected=none", {dmem_we, dmem_a, dmem_wd});
                end else begin
                    check_w("dmem_write", {dmem_we, dmem_a, dmem_wd}, exp_w_q.pop_front());
                end
            end
        end
    end

    // driver + reference model: one whole load/store per call
    task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input bit use_exp, input logic [31:0] exp_val);
        int size, n;
        bit legal, crossing, misal;
        logic [31:0] v;
        logic [31:0] lo;
        size     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal    = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        crossing = !st && (int'(addr[1:0]) + size > 4);
        misal    = st && ((size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00));
        n        = !legal ? 1 : crossing ? 2 : misal ? size : 1;
        lo       = {addr[31:2], 2'b00};
        if (legal && st) begin
            if (misal) begin
                for (int i = 0; i < size; i++) exp_w_q.push_back({WE_BYTE, addr + 32'(i), 24'b0, wd[8*i +: 8]});
            end else begin
                exp_w_q.push_back({(size == 4) ? WE_WORD : (size == 2) ? WE_HALF : WE_BYTE, addr, wd});
            end
            for (int i = 0; i < size; i++) ref_mem[8'(addr + 32'(i))] = wd[8*i +: 8];
        end else if (legal) begin
            v = 32'b0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[8'(addr + 32'(i))];
            if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
            if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
            exp_q.push_back(use_exp ? exp_val : v);
        end
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("stall", 32'(stall), 32'(k < n - 1));
            check("fault", 32'(fault), 32'(!legal));
            check("resp_valid", 32'(resp_valid), 32'(legal && !st && k == n - 1));
            if (!legal) begin
                check("fault_rdata", resp_rdata, 32'b0);
                check("fault_we", 32'(dmem_we), 32'(WE_NONE));
            end
            if (legal && crossing) check("ld_addr", dmem_a, (k == 0) ? lo : lo + 32'd4);
            if (legal && !st && !crossing) check("ld_word", {dmem_a[31:2], 2'b00}, lo);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            check("idle_stall", 32'(stall), 32'd0);
            check("idle_resp", 32'(resp_valid), 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [2:0]  lf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [2:0]  bad [3] = '{3'd3, 3'd6, 3'd7};
        logic [2:0]  f3;
        logic [31:0] addr;
        bit          st;

        reset      = 1'b1;
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = F3_W;
        req_addr   = 32'h0000_000E;
        req_wdata  = 32'h1234_5678;
        #2;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_we", 32'(dmem_we), 32'(WE_NONE));
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        do_op(1, F3_W,  32'h08, 32'hDEADBEEF, 0, 0);
        do_op(0, F3_W,  32'h08, 0, 1, 32'hDEADBEEF);
        do_op(0, F3_B,  32'h09, 0, 1, 32'hFFFFFFBE);
        do_op(0, F3_BU, 32'h09, 0, 1, 32'h000000BE);
        do_op(0, F3_H,  32'h0A, 0, 1, 32'hFFFFDEAD);
        do_op(1, F3_W,  32'h0E, 32'h11223344, 0, 0);
        do_op(0, F3_W,  32'h0C, 0, 1, 32'h33440000);
        do_op(0, F3_W,  32'h10, 0, 1, 32'h00001122);
        do_op(0, F3_W,  32'h0E, 0, 1, 32'h11223344);
        do_op(0, F3_H,  32'h0F, 0, 1, 32'h00002233);

        // misaligned SW aborted by reset during its third cycle
        exp_w_q.push_back({WE_BYTE, 32'h0E, 32'h000000DD});
        exp_w_q.push_back({WE_BYTE, 32'h0F, 32'h000000CC});
        ref_mem[8'h0E] = 8'hDD;
        ref_mem[8'h0F] = 8'hCC;
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = F3_W;
        req_addr   = 32'h0E;
        req_wdata  = 32'hAABBCCDD;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("abort_stall", 32'(stall), 32'd1);
            @(posedge clk);
            #1;
        end
        reset     = 1'b1;
        req_valid = 1'b0;
        #1;
        check("abort_we", 32'(dmem_we), 32'(WE_NONE));
        check("abort_stall_low", 32'(stall), 32'd0);
        check("abort_state", 32'(dbg_state), 32'(S_IDLE));
        @(posedge clk);
        #1;
        reset = 1'b0;
        do_op(0, F3_W, 32'h0C, 0, 1, 32'hCCDD0000);
        do_op(0, F3_W, 32'h10, 0, 1, 32'h00001122);
        do_op(0, F3_W, 32'h08, 0, 1, 32'hDEADBEEF);

        do_op(0, 3'b011, 32'h08, 0, 0, 0);
        do_op(1, 3'b100, 32'h08, 32'hFFFFFFFF, 0, 0);
        do_op(0, F3_W, 32'h08, 0, 1, 32'hDEADBEEF);

        // address wrap at the top of the 32-bit space
        do_op(1, F3_W, 32'hFFFF_FFFE, 32'hCAFEF00D, 0, 0);
        do_op(0, F3_W, 32'hFFFF_FFFE, 0, 1, 32'hCAFEF00D);
        do_op(1, F3_H, 32'hFFFF_FFFF, 32'h00009876, 0, 0);
        do_op(0, F3_HU, 32'hFFFF_FFFF, 0, 1, 32'h00009876);

        for (int t = 0; t < 400; t++) begin
            st   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFC0 + 32'($urandom_range(0, 63))
                                                : 32'($urandom_range(0, 63));
            if ($urandom_range(0, 15) == 0) f3 = st ? 3'($urandom_range(3, 7)) : bad[$urandom_range(0, 2)];
            else f3 = st ? lf3[$urandom_range(0, 2)] : lf3[$urandom_range(0, 4)];
            do_op(st, f3, addr, $urandom, 0, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("resp_queue_drained", 32'(exp_q.size()), 32'd0);
        check("write_queue_drained", 32'(exp_w_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
